bpf_inst_stream_loader: RTL and testbench

BPF_INST_STREAM_LOADER -- requirements
Module: bpf_inst_stream_loader

---
 rtl/bpf_inst_stream_loader.sv | 164 ++++++++++++++++
 tb/tb_bpf_inst_stream_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bpf_inst_stream_loader.sv
`default_nettype none
// ============================================================================
// bpf_inst_stream_loader
// Packs a loader stream into instruction words and writes them to instruction
// memory; flags a resident program once a complete, well-formed load finishes.
// Revision: 1.0
// ============================================================================
module bpf_inst_stream_loader #(
   parameter  int LD_DATA_WIDTH   = 32,
   parameter  int CODE_DATA_WIDTH = 64,
   parameter  int INST_MEM_DEPTH  = 512,
   localparam int CODE_ADDR_WIDTH = $clog2(INST_MEM_DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [LD_DATA_WIDTH-1:0]   ld_TDATA,
   input  logic                       ld_TVALID,
   input  logic                       ld_TLAST,
   output logic                       ld_TREADY,
   output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
   output logic [CODE_DATA_WIDTH-1:0] inst_wr_data,
   output logic                       inst_wr_en,
   output logic                       control_start,
   output logic [CODE_ADDR_WIDTH:0]   prog_len,
   output logic                       load_err
);

   localparam int c_BEATS  = CODE_DATA_WIDTH / LD_DATA_WIDTH;
   localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
   localparam logic [CODE_ADDR_WIDTH:0] c_DEPTH = (CODE_ADDR_WIDTH+1)'(INST_MEM_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t                     r_state,     w_state;
   logic [c_BEAT_W-1:0]        r_beat,      w_beat;
   logic [CODE_ADDR_WIDTH:0]   r_word,      w_word;
   logic [CODE_DATA_WIDTH-1:0] r_asm,       w_asm;
   logic                       r_wr_en,     w_wr_en;
   logic [CODE_ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr;
   logic [CODE_DATA_WIDTH-1:0] r_wr_data,   w_wr_data;
   logic                       r_start,     w_start;
   logic [CODE_ADDR_WIDTH:0]   r_len,       w_len;
   logic                       r_err,       w_err;

   logic                       w_accept;
   logic                       w_fresh;
   logic                       w_last;
   logic [c_BEAT_W-1:0]        w_cur_beat;
   logic [CODE_ADDR_WIDTH:0]   w_cur_word;
   logic [CODE_DATA_WIDTH-1:0] w_word_data;

   // Ready is unconditional once out of reset.
   assign ld_TREADY = ~rst;
   assign w_accept  = ld_TVALID & ld_TREADY;

   always_comb begin
      w_state   = r_state;
      w_beat    = r_beat;
      w_word    = r_word;
      w_asm     = r_asm;
      w_wr_en   = 1'b0;
      w_wr_addr = r_wr_addr;
      w_wr_data = r_wr_data;
      w_start   = r_start;
      w_len     = r_len;
      w_err     = r_err;

      // A beat arriving in IDLE or RUN opens a fresh program at word 0, beat 0.
      w_fresh    = (r_state == ST_IDLE) || (r_state == ST_RUN);
      w_cur_beat = w_fresh ? '0 : r_beat;
      w_cur_word = w_fresh ? '0 : r_word;
      w_last     = (w_cur_beat == c_BEAT_W'(c_BEATS - 1));

      w_word_data = r_asm;
      for (int k = 0; k < c_BEATS; k++) begin
         if (w_cur_beat == c_BEAT_W'(k)) begin
            w_word_data[k*LD_DATA_WIDTH +: LD_DATA_WIDTH] = ld_TDATA;
         end
      end

      if (w_accept) begin
         if (r_state == ST_DRAIN) begin
            if (ld_TLAST) begin
               w_state = ST_IDLE;
            end
         end else begin
            if (w_fresh) begin
               w_err   = 1'b0;
               w_start = 1'b0;
            end
            w_state = ST_LOAD;
            w_asm   = w_word_data;
            w_word  = w_cur_word;
            if (!w_last) begin
               w_beat = w_cur_beat + 1'b1;
               if (ld_TLAST) begin
                  w_err   = 1'b1;
                  w_state = ST_IDLE;
                  w_beat  = '0;
                  w_word  = '0;
               end
            end else begin
               w_beat = '0;
               if (w_cur_word == c_DEPTH) begin
                  // Memory already full: drop the word and swallow the rest.
                  w_err   = 1'b1;
                  w_word  = '0;
                  w_state = ld_TLAST ? ST_IDLE : ST_DRAIN;
               end else begin
                  w_wr_en   = 1'b1;
                  w_wr_addr = w_cur_word[CODE_ADDR_WIDTH-1:0];
                  w_wr_data = w_word_data;
                  w_word    = w_cur_word + 1'b1;
                  if (ld_TLAST) begin
                     w_len   = w_cur_word + 1'b1;
                     w_start = 1'b1;
                     w_state = ST_RUN;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         r_word    <= '0;
         r_asm     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_start   <= 1'b0;
         r_len     <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_beat    <= w_beat;
         r_word    <= w_word;
         r_asm     <= w_asm;
         r_wr_en   <= w_wr_en;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
         r_start   <= w_start;
         r_len     <= w_len;
         r_err     <= w_err;
      end
   end

   assign inst_wr_en    = r_wr_en;
   assign inst_wr_addr  = r_wr_addr;
   assign inst_wr_data  = r_wr_data;
   assign control_start = r_start;
   assign prog_len      = r_len;
   assign load_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bpf_inst_stream_loader.sv
`default_nettype none
// ============================================================================
// tb_bpf_inst_stream_loader
// Directed and randomized programs checked against a word-level reference model.
// Revision: 1.0
// ============================================================================
module tb_bpf_inst_stream_loader;

   localparam int LD    = 32;
   localparam int CODE  = 64;
   localparam int DEPTH = 512;
   localparam int AW    = 9;
   localparam int BEATS = CODE / LD;

   logic            clk = 1'b0;
   logic            rst;
   logic [LD-1:0]   ld_TDATA;
   logic            ld_TVALID;
   logic            ld_TLAST;
   logic            ld_TREADY;
   logic [AW-1:0]   inst_wr_addr;
   logic [CODE-1:0] inst_wr_data;
   logic            inst_wr_en;
   logic            control_start;
   logic [AW:0]     prog_len;
   logic            load_err;

   int n_assert = 0;
   int n_fail   = 0;
   int exp_len  = 0;

   logic [LD-1:0]   prog[$];
   int              mon_addr[$];
   logic [CODE-1:0] mon_data[$];
   logic            mon_start[$];

   bpf_inst_stream_loader #(
      .LD_DATA_WIDTH   (LD),
      .CODE_DATA_WIDTH (CODE),
      .INST_MEM_DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ld_TDATA      (ld_TDATA),
      .ld_TVALID     (ld_TVALID),
      .ld_TLAST      (ld_TLAST),
      .ld_TREADY     (ld_TREADY),
      .inst_wr_addr  (inst_wr_addr),
      .inst_wr_data  (inst_wr_data),
      .inst_wr_en    (inst_wr_en),
      .control_start (control_start),
      .prog_len      (prog_len),
      .load_err      (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (inst_wr_en === 1'b1) begin
         mon_addr.push_back(int'(inst_wr_addr));
         mon_data.push_back(inst_wr_data);
         mon_start.push_back(control_start);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_beat(input logic [LD-1:0] d, input logic last);
      ld_TDATA  = d;
      ld_TLAST  = last;
      ld_TVALID = 1'b1;
      @(posedge clk); #1;
      ld_TVALID = 1'b0;
      ld_TLAST  = 1'b0;
   endtask

   // Idle cycles carry junk on data/last so a gap that disturbs assembly shows up.
   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         ld_TDATA = $urandom;
         ld_TLAST = 1'($urandom);
         @(posedge clk); #1;
      end
      ld_TLAST = 1'b0;
   endtask

   task automatic send_prog(input int gap_pos, input int gap_len, input int rand_gap,
                            input bit chk_first);
      mon_addr.delete();
      mon_data.delete();
      mon_start.delete();
      for (int i = 0; i < prog.size(); i++) begin
         int g;
         g = (i == gap_pos) ? gap_len : ((rand_gap > 0) ? int'($urandom_range(rand_gap, 0)) : 0);
         idle(g);
         send_beat(prog[i], i == prog.size() - 1);
         if (chk_first && i == 0) begin
            check("first_beat_start_clr", control_start, 0);
            check("first_beat_err_clr", load_err, 0);
         end
      end
      idle(3);
   endtask

   task automatic check_prog(input string tag);
      int  n, words, nw;
      bit  ok;
      n     = prog.size();
      words = n / BEATS;
      ok    = (n % BEATS == 0) && (words <= DEPTH);
      nw    = (words < DEPTH) ? words : DEPTH;
      if (ok) exp_len = words;
      check({tag, "_nwrites"}, mon_addr.size(), nw);
      for (int i = 0; i < nw && i < mon_addr.size(); i++) begin
         check({tag, "_addr"}, mon_addr[i], i);
         check({tag, "_data"}, mon_data[i], {prog[2*i+1], prog[2*i]});
         check({tag, "_start_at_wr"}, mon_start[i], (ok && i == nw - 1) ? 1 : 0);
      end
      check({tag, "_prog_len"}, prog_len, exp_len);
      check({tag, "_load_err"}, load_err, ok ? 0 : 1);
      check({tag, "_control_start"}, control_start, ok ? 1 : 0);
      check({tag, "_tready"}, ld_TREADY, 1);
   endtask

   initial begin
      rst       = 1'b1;
      ld_TDATA  = '0;
      ld_TVALID = 1'b0;
      ld_TLAST  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tready", ld_TREADY, 0);
      check("rst_wr_en", inst_wr_en, 0);
      check("rst_start", control_start, 0);
      check("rst_prog_len", prog_len, 0);
      check("rst_load_err", load_err, 0);
      rst = 1'b0;
      idle(2);

      // Six back-to-back beats, three words, program resident afterwards.
      prog = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
      send_prog(-1, 0, 0, 0);
      check_prog("b2b6");

      // New beat while RUN: start drops immediately, rewrite from address 0.
      prog = {32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6};
      send_prog(-1, 0, 0, 1);
      check_prog("reload_in_run");

      // Same stream with a three-cycle TVALID gap after the first beat.
      prog = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
      send_prog(1, 3, 0, 0);
      check_prog("gap3");

      // TLAST on a partial word.
      prog = {32'h11, 32'h12, 32'h13};
      send_prog(-1, 0, 0, 0);
      check_prog("partial_last");

      // Asynchronous reset part-way through a load.
      prog = {32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26};
      send_prog(-1, 0, 0, 0);
      send_beat(32'h31, 1'b0);
      send_beat(32'h32, 1'b0);
      send_beat(32'h33, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tready", ld_TREADY, 0);
      check("async_rst_wr_data", inst_wr_data, 0);
      check("async_rst_wr_addr", inst_wr_addr, 0);
      check("async_rst_start", control_start, 0);
      check("async_rst_prog_len", prog_len, 0);
      @(posedge clk); #1;
      rst     = 1'b0;
      exp_len = 0;
      idle(1);
      prog = {$urandom, $urandom};
      send_prog(-1, 0, 0, 0);
      check_prog("after_rst");

      // Overflow with TLAST on the word that does not fit.
      prog.delete();
      for (int i = 0; i < 1026; i++) prog.push_back($urandom);
      send_prog(-1, 0, 0, 0);
      check_prog("overflow_1026");

      // Overflow followed by extra beats drained up to TLAST.
      prog.delete();
      for (int i = 0; i < 1031; i++) prog.push_back($urandom);
      send_prog(-1, 0, 0, 0);
      check_prog("overflow_drain");

      // Randomized programs with random lengths and TVALID gaps.
      for (int p = 0; p < 25; p++) begin
         int len;
         len = int'($urandom_range(14, 1));
         prog.delete();
         for (int i = 0; i < len; i++) prog.push_back($urandom);
         send_prog(-1, 0, 3, 0);
         check_prog("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
